// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb puzzle: button encoding used by the random
// source, the button encoder and the challenge controller.
package bomb_pkg;

    localparam int NUM_BUTTONS = 12;

    typedef logic [3:0] btn_code_t;

    localparam btn_code_t BTN_UP1    = 4'd0;
    localparam btn_code_t BTN_DOWN1  = 4'd1;
    localparam btn_code_t BTN_RIGHT1 = 4'd2;
    localparam btn_code_t BTN_LEFT1  = 4'd3;
    localparam btn_code_t BTN_A1     = 4'd4;
    localparam btn_code_t BTN_B1     = 4'd5;
    localparam btn_code_t BTN_UP2    = 4'd6;
    localparam btn_code_t BTN_DOWN2  = 4'd7;
    localparam btn_code_t BTN_RIGHT2 = 4'd8;
    localparam btn_code_t BTN_LEFT2  = 4'd9;
    localparam btn_code_t BTN_A2     = 4'd10;
    localparam btn_code_t BTN_B2     = 4'd11;

    // Codes 12..15 from the random source have no button and must be skipped.
    function automatic logic is_button_code(input btn_code_t c);
        return c < btn_code_t'(NUM_BUTTONS);
    endfunction

endpackage

// File: rtl/challenge_timer.sv
// Loadable down-counter: clear reloads CYCLES-1, en counts down, expired marks
// the last cycle of a CYCLES-long interval.
module challenge_timer #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= LOAD;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/button_challenge_ctrl.sv
// Button-prompt challenge sequencer: captures a random challenge, shows it one
// prompt at a time, then checks the player's presses with a per-press timeout.
module button_challenge_ctrl
    import bomb_pkg::*;
#(
    parameter int SEQ_LEN        = 8,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rand_code,
    input  logic       btn_valid,
    input  logic [3:0] btn_code,
    output logic       busy,
    output logic       prompt_valid,
    output logic [3:0] prompt_code,
    output logic [3:0] progress,
    output logic       pass,
    output logic       fail
);

    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

    typedef enum logic [2:0] {IDLE, GEN, SHOW, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    chal_buf [SEQ_LEN];
    logic [IW-1:0] wr_idx, wr_idx_n;
    logic [IW-1:0] rd_idx, rd_idx_n;
    logic [3:0]    progress_n;
    logic          result_pass, result_n;
    logic          wr_en;
    logic          show_clr, show_en, show_exp;
    logic          tmo_clr, tmo_en, tmo_exp;
    logic [3:0]    cur_code;

    assign cur_code = chal_buf[rd_idx];

    challenge_timer #(.CYCLES(SHOW_CYCLES)) u_show_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (show_clr),
        .en      (show_en),
        .expired (show_exp)
    );

    challenge_timer #(.CYCLES(TIMEOUT_CYCLES)) u_press_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_idx      <= '0;
            rd_idx      <= '0;
            progress    <= '0;
            result_pass <= 1'b0;
        end else begin
            state       <= state_n;
            wr_idx      <= wr_idx_n;
            rd_idx      <= rd_idx_n;
            progress    <= progress_n;
            result_pass <= result_n;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en)
            chal_buf[wr_idx] <= rand_code;
    end

    always_comb begin
        state_n    = state;
        wr_idx_n   = wr_idx;
        rd_idx_n   = rd_idx;
        progress_n = progress;
        result_n   = result_pass;
        wr_en      = 1'b0;
        show_clr   = 1'b0;
        show_en    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        unique case (state)
            IDLE: begin
                // progress survives in IDLE so the display can keep showing it.
                if (start) begin
                    state_n    = GEN;
                    wr_idx_n   = '0;
                    rd_idx_n   = '0;
                    progress_n = '0;
                    tmo_clr    = 1'b1;
                end
            end
            GEN: begin
                if (is_button_code(rand_code)) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST) begin
                        state_n  = SHOW;
                        rd_idx_n = '0;
                        show_clr = 1'b1;
                    end else begin
                        wr_idx_n = wr_idx + 1'b1;
                    end
                end
            end
            SHOW: begin
                if (show_exp) begin
                    if (rd_idx == LAST) begin
                        state_n  = WAIT;
                        rd_idx_n = '0;
                        tmo_clr  = 1'b1;
                    end else begin
                        rd_idx_n = rd_idx + 1'b1;
                        show_clr = 1'b1;
                    end
                end else begin
                    show_en = 1'b1;
                end
            end
            WAIT: begin
                // A press wins over a timeout expiring in the same cycle.
                if (btn_valid) begin
                    if (btn_code == cur_code) begin
                        progress_n = progress + 4'd1;
                        tmo_clr    = 1'b1;
                        if (rd_idx == LAST) begin
                            state_n  = DONE;
                            result_n = 1'b1;
                        end else begin
                            rd_idx_n = rd_idx + 1'b1;
                        end
                    end else begin
                        state_n  = DONE;
                        result_n = 1'b0;
                    end
                end else if (tmo_exp) begin
                    state_n  = DONE;
                    result_n = 1'b0;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign prompt_valid = (state == SHOW);
    assign prompt_code  = prompt_valid ? cur_code : 4'd0;
    assign pass         = (state == DONE) &&  result_pass;
    assign fail         = (state == DONE) && !result_pass;

endmodule
